// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e : request FSM encoding (IDLE, ADDR, DATA)
//   INST_W        : instruction word width
//   PC_INC        : sequential pc step in bytes
//   FIFO_DEPTH    : entries in the fetch buffer
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request in progress
        ADDR = 2'd1,   // address presented, waiting for i_raddr_ready
        DATA = 2'd2    // one read outstanding, waiting for i_rdata_valid
    } fetch_state_e;

    localparam int INST_W     = 32;
    localparam int PC_INC     = 4;
    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO holding fetched {instruction, pc} entries.
//   clk, rst     : clock, asynchronous active-low reset
//   push, push_data : write an entry (accepted when not full, or when popping)
//   pop          : drop the head entry (ignored when empty)
//   flush        : discard all entries; wins over push/pop
//   head_data    : head entry, zero after reset
//   full, empty, count : occupancy status
module fetch_buffer #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // When full, push+pop writes the slot being read this cycle; the read
    // is combinational so the outgoing head is delivered before overwrite.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one read at a time to instruction memory,
// buffers returned words in a 2-entry FIFO and presents them to decode.
// Redirects flush the buffer and restart fetch at the (word-aligned) target;
// a response already in flight is accepted and dropped.
//   clk, rst                         : clock, asynchronous active-low reset
//   i_raddr_valid/ready, i_raddr     : read-address channel (out)
//   i_rdata_valid/ready, i_rdata     : read-data channel (in)
//   redirect_valid, redirect_pc      : branch/jump target pulse
//   inst_valid/ready, inst, inst_pc  : instruction channel to decode
// pc_width must not exceed bus_width.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  bus_width = INST_W,
    parameter int                  pc_width  = 32,
    parameter logic [pc_width-1:0] pc_init   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 i_raddr_valid,
    input  logic                 i_raddr_ready,
    output logic [bus_width-1:0] i_raddr,
    input  logic                 i_rdata_valid,
    output logic                 i_rdata_ready,
    input  logic [bus_width-1:0] i_rdata,
    input  logic                 redirect_valid,
    input  logic [pc_width-1:0]  redirect_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [bus_width-1:0] inst,
    output logic [pc_width-1:0]  inst_pc
);

    localparam int ENTRY_W = bus_width + pc_width;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    fetch_state_e        state_q, state_d;
    logic [pc_width-1:0] pc_q, pc_d;          // address of the next request
    logic [pc_width-1:0] req_pc_q, req_pc_d;  // address of the current request
    logic                discard_q, discard_d;

    logic                addr_hs, data_hs, inst_hs;
    logic                push, issue;
    logic [pc_width-1:0] redirect_aligned, pc_eff;
    logic [CNT_W:0]      occ_next;
    logic [ENTRY_W-1:0]  head;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    assign addr_hs = i_raddr_valid && i_raddr_ready;
    assign data_hs = i_rdata_valid && i_rdata_ready;
    assign inst_hs = inst_valid && inst_ready;

    assign redirect_aligned = redirect_pc & ~pc_width'(3);
    assign pc_eff           = redirect_valid ? redirect_aligned : pc_q;

    // A word returning alongside a redirect belongs to the old path.
    assign push = data_hs && !discard_q && !redirect_valid;

    // Occupancy once this cycle's push/pop/flush has landed.
    assign occ_next = redirect_valid ? '0
                    : ({1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(inst_hs));

    always_comb begin
        state_d   = state_q;
        pc_d      = redirect_valid ? redirect_aligned : pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        issue     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_full) begin
                    issue   = 1'b1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (addr_hs) state_d = DATA;
            end
            DATA: begin
                if (data_hs) begin
                    issue   = (occ_next < (CNT_W+1)'(FIFO_DEPTH));
                    state_d = issue ? ADDR : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The request address is captured when ADDR is entered so it stays
        // frozen until the handshake; pc advances past it at the same time,
        // which is equivalent to stepping pc on the address handshake since
        // only one request is ever open.
        if (issue) begin
            req_pc_d = pc_eff;
            pc_d     = pc_eff + pc_width'(PC_INC);
        end

        if (data_hs) discard_d = 1'b0;
        // Any request already handed to (or being handed to) memory must
        // have its response thrown away, unless it is returning right now.
        if (redirect_valid && ((state_q == ADDR) || (state_q == DATA && !data_hs)))
            discard_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= pc_init;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            discard_q <= discard_d;
        end
    end

    assign i_raddr_valid = (state_q == ADDR);
    assign i_raddr       = (state_q == ADDR) ? bus_width'(req_pc_q) : '0;
    assign i_rdata_ready = (state_q == DATA);

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({i_rdata, req_pc_q}),
        .pop       (inst_hs),
        .flush     (redirect_valid),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = head[ENTRY_W-1 -: bus_width];
    assign inst_pc    = head[pc_width-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle tables for streaming, back-pressure
// and redirect behaviour, plus hand sequences for reset mid-read and pc wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_raddr_valid, i_raddr_ready;
    logic [31:0] i_raddr;
    logic        i_rdata_valid, i_rdata_ready;
    logic [31:0] i_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    // second instance exercising pc wrap
    logic        w_raddr_valid, w_rdata_valid, w_rdata_ready, w_inst_valid;
    logic        w_raddr_ready = 1'b1, w_inst_ready = 1'b1, w_redirect = 1'b0;
    logic [31:0] w_raddr, w_rdata, w_inst, w_inst_pc;
    logic [31:0] w_redirect_pc = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // memory model: one-cycle response, can be held off with gate
    logic        pend = 1'b0, gate = 1'b1;
    logic [31:0] maddr = 32'h0;
    always @(posedge clk) begin
        if (i_raddr_valid && i_raddr_ready) begin
            pend  <= 1'b1;
            maddr <= i_raddr;
        end else if (i_rdata_valid && i_rdata_ready) begin
            pend <= 1'b0;
        end
    end
    assign i_rdata_valid = pend && gate;
    assign i_rdata       = word(maddr);

    logic        w_pend = 1'b0;
    logic [31:0] w_maddr = 32'h0;
    always @(posedge clk) begin
        if (w_raddr_valid && w_raddr_ready) begin
            w_pend  <= 1'b1;
            w_maddr <= w_raddr;
        end else if (w_rdata_valid && w_rdata_ready) begin
            w_pend <= 1'b0;
        end
    end
    assign w_rdata_valid = w_pend;
    assign w_rdata       = word(w_maddr);

    fetch_unit #(.bus_width(32), .pc_width(32), .pc_init(32'h0)) dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
        .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.bus_width(32), .pc_width(32), .pc_init(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .i_raddr_valid(w_raddr_valid), .i_raddr_ready(w_raddr_ready), .i_raddr(w_raddr),
        .i_rdata_valid(w_rdata_valid), .i_rdata_ready(w_rdata_ready), .i_rdata(w_rdata),
        .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        gate           = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    typedef struct {
        bit          rb;   // reset before this row
        bit          ar, ir, g, rv;
        logic [31:0] rpc;
        bit          e_av;
        logic [31:0] e_a;
        bit          e_rr, e_iv;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rb, bit ar, bit ir, bit g, bit rv, logic [31:0] rpc,
                                bit av, logic [31:0] a, bit rr, bit iv, logic [31:0] ipc);
        vec_t v;
        v.rb = rb; v.ar = ar; v.ir = ir; v.g = g; v.rv = rv; v.rpc = rpc;
        v.e_av = av; v.e_a = a; v.e_rr = rr; v.e_iv = iv; v.e_ipc = ipc;
        return v;
    endfunction

    initial begin
        i_raddr_ready  = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Streaming, then inst_ready low (FIFO fills), then i_raddr_ready low
        //           rb ar ir g  rv rpc       av a         rr iv ipc
        tbl.push_back(mk(1, 1, 1, 1, 0, 0,        0, 32'h0,   0, 0, 32'h0));  // A0
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h0,   0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h4,   0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,        1, 32'h8,   0, 1, 32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,        1, 32'h8,   0, 1, 32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0,        1, 32'h8,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        1, 32'h8,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   1, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   0, 1, 32'h8));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'hC,   0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h10,  0, 1, 32'hC));
        // Redirect cases
        tbl.push_back(mk(1, 1, 1, 1, 0, 0,        0, 32'h0,   0, 0, 32'h0));  // B0
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h0,   0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h4,   0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        1, 32'h8,   0, 1, 32'h4));
        tbl.push_back(mk(0, 1, 0, 0, 1, 32'h100,  0, 32'h0,   1, 1, 32'h4));  // redirect in DATA
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));  // 0x8 dropped
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        1, 32'h100, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h303,  1, 32'h104, 0, 1, 32'h100)); // redirect in ADDR
        tbl.push_back(mk(0, 0, 1, 1, 0, 0,        1, 32'h104, 0, 0, 32'h0));  // address held
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h104, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h300, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h304, 0, 1, 32'h300));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h202,  0, 32'h0,   1, 0, 32'h0));  // redirect with data hs
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h200, 0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 32'h400,  1, 32'h204, 0, 1, 32'h200)); // redirect with inst hs
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        0, 32'h0,   1, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0,        1, 32'h400, 0, 0, 32'h0));

        foreach (tbl[i]) begin
            if (tbl[i].rb) do_reset();
            i_raddr_ready  = tbl[i].ar;
            inst_ready     = tbl[i].ir;
            gate           = tbl[i].g;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d i_raddr_valid", i), 32'(i_raddr_valid), 32'(tbl[i].e_av));
            chk($sformatf("row%0d i_raddr", i), i_raddr, tbl[i].e_a);
            chk($sformatf("row%0d i_rdata_ready", i), 32'(i_rdata_ready), 32'(tbl[i].e_rr));
            chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
            if (tbl[i].e_iv) begin
                chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
                chk($sformatf("row%0d inst", i), inst, word(tbl[i].e_ipc));
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;

        // Reset asserted while a read is outstanding
        do_reset();
        i_raddr_ready = 1'b1;
        inst_ready    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        gate = 1'b0;                     // hold off the response for 0x4
        chk("pre-reset i_rdata_ready", 32'(i_rdata_ready), 32'd1);
        chk("pre-reset inst_valid", 32'(inst_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst i_raddr_valid", 32'(i_raddr_valid), 32'd0);
        chk("async rst i_raddr", i_raddr, 32'h0);
        chk("async rst i_rdata_ready", 32'(i_rdata_ready), 32'd0);
        chk("async rst inst_valid", 32'(inst_valid), 32'd0);
        chk("async rst inst", inst, 32'h0);
        chk("async rst inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        gate = 1'b1;                     // late response now visible
        rst  = 1'b1;
        @(negedge clk);
        chk("post-rst late data ignored", 32'(i_rdata_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-rst restart valid", 32'(i_raddr_valid), 32'd1);
        chk("post-rst restart addr", i_raddr, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-rst first inst_valid", 32'(inst_valid), 32'd1);
        chk("post-rst first inst_pc", inst_pc, 32'h0);
        chk("post-rst first inst", inst, word(32'h0));

        // pc wrap on the second instance (all readies high)
        do_reset();
        @(negedge clk);
        chk("wrap c0 raddr_valid", 32'(w_raddr_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap c1 raddr", w_raddr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap c3 raddr", w_raddr, 32'h0);
        chk("wrap c3 inst_pc", w_inst_pc, 32'hFFFF_FFFC);
        chk("wrap c3 inst", w_inst, word(32'hFFFF_FFFC));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap c5 inst_valid", 32'(w_inst_valid), 32'd1);
        chk("wrap c5 inst_pc", w_inst_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter bus_width, default 32: bus data/address width.
REQ-002 Parameter pc_width, default 32: program counter width; the design SHALL use pc_width <= bus_width.
REQ-003 Parameter pc_init, default 0: first fetch address after reset.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 i_raddr_valid  output  1  instruction read-address request valid.
REQ-007 i_raddr_ready  input  1  memory accepts the address.
REQ-008 i_raddr  output  bus_width  fetch address, zero-extended pc.
REQ-009 i_rdata_valid  input  1  memory returns a word.
REQ-010 i_rdata_ready  output  1  fetch accepts the returned word.
REQ-011 i_rdata  input  bus_width  returned instruction word.
REQ-012 redirect_valid  input  1  single-cycle pulse carrying a branch or jump target.
REQ-013 redirect_pc  input  pc_width  new fetch address.
REQ-014 inst_valid  output  1  instruction available to decode.
REQ-015 inst_ready  input  1  decode consumes the instruction.
REQ-016 inst  output  bus_width  instruction word.
REQ-017 inst_pc  output  pc_width  address of inst.

Function
REQ-018 A handshake SHALL occur on a channel in any cycle where valid and ready are both high.
REQ-019 The FSM SHALL have three states: IDLE (no request), ADDR (i_raddr_valid high), DATA (awaiting i_rdata).
REQ-020 IDLE->ADDR SHALL occur when buffer occupancy is < 2; otherwise the FSM SHALL stay in IDLE.
REQ-021 ADDR->DATA SHALL occur on the address handshake: pc_req <= pc; pc <= pc+4 modulo 2^pc_width, so the address wraps to 0.
REQ-022 Once raised, i_raddr_valid and i_raddr SHALL stay stable until the handshake; redirect SHALL NOT drop them.
REQ-023 In DATA, i_rdata_ready SHALL be 1; in IDLE and ADDR it SHALL be 0.
REQ-024 At most one read SHALL be outstanding.
REQ-025 On the data handshake, {i_rdata, pc_req} SHALL be pushed to the buffer unless the discard flag is set; the FSM SHALL then go to ADDR if occupancy after this cycle's push/pop is < 2, else to IDLE.
REQ-026 The buffer SHALL be a 2-entry FIFO; inst, inst_pc and inst_valid SHALL be driven from the head entry.
REQ-027 Push and pop in the same cycle SHALL be allowed at any occupancy, including full.
REQ-028 Best-case latency SHALL be: address handshake at cycle N, data at N+1, inst_valid high at N+2. With all readies high, throughput SHALL be one instruction per 2 cycles.
REQ-029 On redirect_valid, the next pc SHALL be redirect_pc with bits [1:0] cleared, and the FIFO SHALL be flushed (inst_valid low the next cycle).
REQ-030 On redirect_valid in DATA, or in ADDR with or without a same-cycle handshake, the discard flag SHALL be set, so that the in-flight response is accepted and dropped.
REQ-031 The discard flag SHALL clear when the discarded response handshakes.
REQ-032 The first request after a redirect SHALL use the redirect address.
REQ-033 A redirect coinciding with a data handshake SHALL drop that word and SHALL NOT set the discard flag.
REQ-034 A redirect coinciding with an inst handshake SHALL still flush; the consumed entry counts as delivered.

Reset
REQ-035 While rst=0: state=IDLE, pc=pc_init, FIFO empty, discard flag=0, i_raddr_valid=0, i_rdata_ready=0, inst_valid=0; inst, inst_pc and i_raddr SHALL be 0.
REQ-036 Reset SHALL abort any outstanding transaction without waiting for the memory.
REQ-037 The first request SHALL assert i_raddr_valid on the first clock edge after rst deasserts.

Structure
REQ-038 A shared package SHALL hold the FSM state encoding (IDLE, ADDR, DATA), the instruction width constant and the pc increment of 4.
REQ-039 The FIFO SHALL be a sub-module named fetch_buffer, parameterized by width and depth=2, with push, pop, flush, full, empty and count.

Verification
REQ-040 Reset released, all readies held high, memory returning 0x00000013 -> i_raddr sequence 0x0, 0x4, 0x8; inst_pc 0x0, 0x4, 0x8; first inst_valid at cycle 3.
REQ-041 inst_ready held low -> exactly 2 entries buffered (pc 0x0, 0x4); i_raddr_valid stays low until inst_ready rises.
REQ-042 i_raddr_ready low for 3 cycles with i_raddr=0x8 -> i_raddr_valid high and i_raddr=0x8 held constant each cycle.
REQ-043 redirect_valid with redirect_pc=0x100 while in DATA for 0x8 -> response for 0x8 dropped, FIFO empty; the next i_raddr is 0x100 and the next inst_pc is 0x100.
REQ-044 pc_init=0xFFFFFFFC -> fetches 0xFFFFFFFC then 0x0.
REQ-045 rst asserted mid-DATA -> all outputs reach reset values immediately; after release, the fetch restarts at pc_init and the late i_rdata_valid is ignored.
